// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Reason for the current ID stall; exposed for debug/perf counters.
    typedef enum logic [2:0] {
        STALL_NONE,
        STALL_RAW,
        STALL_WAW,
        STALL_LOADUSE,
        STALL_FULL
    } stall_cause_e;

endpackage

// File: rtl/sb_tag_fifo.sv
// In-order FIFO of destination tags for outstanding long-latency ops.
module sb_tag_fifo
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] tag_i,
    input  logic                  pop_i,
    output logic [REG_ADDR_W-1:0] head_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Pointer, count and storage update; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= tag_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push_i && !pop_i) begin
                r_count <= r_count + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks registers awaiting long-latency results and stalls ID on RAW/WAW,
// load-use and tag-FIFO-full hazards.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic                  id_wen_n_i,
    input  logic                  id_long_i,
    input  logic                  id_valid_i,
    input  logic                  flush_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  lu_done_i,
    output logic                  stall_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic [CNT_W-1:0]      pending_cnt_o,
    output logic                  full_o,
    output logic                  err_o
);

    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic                  r_err;
    logic [REG_ADDR_W-1:0] w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_done;
    logic                  w_issue;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_loaduse;
    logic                  w_struct;
    stall_cause_e          w_cause;

    // A completion only counts when something is outstanding.
    assign w_done = lu_done_i & ~w_empty;

    // A same-cycle completion of the register releases RAW/WAW; WB forwarding supplies it.
    assign w_raw =
        (id_use_rs1_i & r_busy[id_rs1_i] & (id_rs1_i != '0) & ~(w_done & (w_head == id_rs1_i))) |
        (id_use_rs2_i & r_busy[id_rs2_i] & (id_rs2_i != '0) & ~(w_done & (w_head == id_rs2_i)));
    assign w_waw = id_long_i & ~id_wen_n_i & r_busy[id_rd_i] & (id_rd_i != '0) &
                   ~(w_done & (w_head == id_rd_i));
    assign w_loaduse = ex_load_i & (ex_rd_i != '0) &
                       ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                        (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    assign w_struct = id_long_i & w_full & ~w_done;

    // Prioritised stall cause; a flushed or invalid ID slot never stalls.
    always_comb begin
        w_cause = STALL_NONE;
        if (id_valid_i && !flush_i) begin
            if (w_raw)          w_cause = STALL_RAW;
            else if (w_waw)     w_cause = STALL_WAW;
            else if (w_loaduse) w_cause = STALL_LOADUSE;
            else if (w_struct)  w_cause = STALL_FULL;
        end
    end

    assign stall_o = (w_cause != STALL_NONE);
    assign w_issue = id_valid_i & ~flush_i & ~stall_o & id_long_i;

    // Busy next state: clear popped head first so a same-register issue wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_done) begin
            w_busy_next[w_head] = 1'b0;
        end
        if (w_issue && !id_wen_n_i && (id_rd_i != '0)) begin
            w_busy_next[id_rd_i] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Busy vector and sticky underflow error.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (lu_done_i && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tags are pushed even for x0 / no-write ops so completions stay in order.
    sb_tag_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_issue),
        .tag_i   (id_rd_i),
        .pop_i   (w_done),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign busy_o        = r_busy;
    assign pending_cnt_o = w_count;
    assign full_o        = w_full;
    assign err_o         = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, ex_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i, id_wen_n_i, id_long_i, id_valid_i;
    logic        flush_i, ex_load_i, lu_done_i;
    logic        stall_o, full_o, err_o;
    logic [31:0] busy_o;
    logic [2:0]  pending_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    hazard_scoreboard #(
        .DEPTH (4),
        .CNT_W (3)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .id_wen_n_i    (id_wen_n_i),
        .id_long_i     (id_long_i),
        .id_valid_i    (id_valid_i),
        .flush_i       (flush_i),
        .ex_load_i     (ex_load_i),
        .ex_rd_i       (ex_rd_i),
        .lu_done_i     (lu_done_i),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .pending_cnt_o (pending_cnt_o),
        .full_o        (full_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; ex_rd_i = 0;
        id_use_rs1_i = 0; id_use_rs2_i = 0; id_wen_n_i = 1; id_long_i = 0;
        id_valid_i = 0; flush_i = 0; ex_load_i = 0; lu_done_i = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        id_valid_i = 1; id_long_i = 1; id_wen_n_i = 0; id_rd_i = rd;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        reset_i = 1;
        #1;
        check("rst_busy", busy_o, 32'h0);
        check("rst_cnt", 32'(pending_cnt_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_full", 32'(full_o), 0);
        #2 reset_i = 0;
        step();

        // Reset while an op is outstanding clears state without a clock edge.
        issue_long(5);
        step();
        check("mid_busy5", busy_o, 32'h20);
        check("mid_cnt", 32'(pending_cnt_o), 1);
        idle();
        id_valid_i = 1; id_use_rs1_i = 1; id_rs1_i = 5;
        #1;
        check("mid_stall_pre", 32'(stall_o), 1);
        #1 reset_i = 1;
        #1;
        check("mid_rst_busy", busy_o, 32'h0);
        check("mid_rst_cnt", 32'(pending_cnt_o), 0);
        check("mid_rst_stall", 32'(stall_o), 0);
        #1 reset_i = 0;
        idle();
        step();

        // RAW on a long op: stall until the completing cycle.
        issue_long(7);
        step();
        idle();
        id_valid_i = 1; id_use_rs1_i = 1; id_rs1_i = 7;
        #1;
        check("raw_stall0", 32'(stall_o), 1);
        step();
        check("raw_stall1", 32'(stall_o), 1);
        check("raw_busy7", busy_o, 32'h80);
        lu_done_i = 1;
        #1;
        check("raw_release", 32'(stall_o), 0);
        step();
        check("raw_busy_clr", busy_o, 32'h0);
        check("raw_cnt", 32'(pending_cnt_o), 0);
        idle();

        // Load-use against EX.
        id_valid_i = 1; ex_load_i = 1; ex_rd_i = 3; id_use_rs2_i = 1; id_rs2_i = 3;
        #1;
        check("lu_stall", 32'(stall_o), 1);
        ex_rd_i = 0; id_rs2_i = 0;
        #1;
        check("lu_x0", 32'(stall_o), 0);
        ex_rd_i = 3; id_rs2_i = 3; id_use_rs2_i = 0;
        #1;
        check("lu_nouse", 32'(stall_o), 0);
        id_use_rs2_i = 1; flush_i = 1;
        #1;
        check("lu_flush", 32'(stall_o), 0);
        idle();
        step();

        // Fill the tag FIFO, then hit the structural limit.
        for (int r = 1; r <= 4; r++) begin
            issue_long(5'(r));
            step();
        end
        idle();
        check("full_flag", 32'(full_o), 1);
        check("full_cnt", 32'(pending_cnt_o), 4);
        check("full_busy", busy_o, 32'h1E);
        issue_long(5);
        #1;
        check("full_stall", 32'(stall_o), 1);
        step();
        check("full_hold_cnt", 32'(pending_cnt_o), 4);
        check("full_no_push", busy_o, 32'h1E);
        lu_done_i = 1;
        #1;
        check("full_done_stall", 32'(stall_o), 0);
        step();
        check("full_swap_cnt", 32'(pending_cnt_o), 4);
        check("full_swap_busy", busy_o, 32'h3C);
        idle();
        lu_done_i = 1;
        for (int k = 0; k < 4; k++) step();
        lu_done_i = 0;
        check("drain_cnt", 32'(pending_cnt_o), 0);
        check("drain_busy", busy_o, 32'h0);
        check("drain_err", 32'(err_o), 0);

        // Same register issued as the head completes: set wins.
        issue_long(9);
        step();
        lu_done_i = 1;
        #1;
        check("same_stall", 32'(stall_o), 0);
        step();
        check("same_busy", busy_o, 32'h200);
        check("same_cnt", 32'(pending_cnt_o), 1);
        idle();
        lu_done_i = 1;
        step();
        check("same_drain", busy_o, 32'h0);

        // Completion with nothing outstanding sets a sticky error.
        step();
        check("err_set", 32'(err_o), 1);
        check("err_cnt", 32'(pending_cnt_o), 0);
        idle();
        step();
        check("err_sticky", 32'(err_o), 1);

        // Flush suppresses both the stall and the push.
        issue_long(6);
        step();
        issue_long(10);
        id_use_rs1_i = 1; id_rs1_i = 6; flush_i = 1;
        #1;
        check("flush_stall", 32'(stall_o), 0);
        step();
        check("flush_cnt", 32'(pending_cnt_o), 1);
        check("flush_busy", busy_o, 32'h40);

        // x0 destination is pushed but never marked busy.
        issue_long(0);
        step();
        check("x0_cnt", 32'(pending_cnt_o), 2);
        check("x0_busy", busy_o, 32'h40);
        idle();
        id_valid_i = 1; id_use_rs1_i = 1; id_rs1_i = 0;
        #1;
        check("x0_stall", 32'(stall_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side counterpart to the EX-stage forwarding logic.
- Forwarding resolves hazards by bypassing values that already exist. This block tracks destination registers whose values do not exist yet, and stalls the ID stage until they do.
- Covers two cases:
  - results still in flight from the long-latency unit (loads, mul/div), which complete in order;
  - load-use hazards against the instruction currently in EX.
- Sits between ID and EX. Its stall output freezes PC/IF/ID and injects a bubble into EX.

Parameters:
- DEPTH, 4, maximum outstanding long-latency ops (tag FIFO depth, power of 2, ≥2).
- CNT_W, 3, width of pending_cnt_o; must hold DEPTH (log2(DEPTH)+1).

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- id_rs1_i  in  5  ID-stage source register 1.
- id_rs2_i  in  5  ID-stage source register 2.
- id_rd_i  in  5  ID-stage destination register.
- id_use_rs1_i  in  1  instruction reads rs1.
- id_use_rs2_i  in  1  instruction reads rs2.
- id_wen_n_i  in  1  instruction writes rd (active-low, same polarity as pipeline wb flags).
- id_long_i  in  1  instruction is dispatched to the long-latency unit.
- id_valid_i  in  1  ID holds a valid instruction.
- flush_i  in  1  branch/trap flush of IF/ID this cycle.
- ex_load_i  in  1  EX holds a load.
- ex_rd_i  in  5  EX-stage destination register.
- lu_done_i  in  1  long-latency unit retires its oldest op this cycle (in order).
- stall_o  out  1  hold ID, bubble EX (combinational).
- busy_o  out  32  busy bit per register; bit 0 always 0.
- pending_cnt_o  out  CNT_W  outstanding long ops.
- full_o  out  1  pending_cnt_o == DEPTH.
- err_o  out  1  sticky: lu_done_i received with no outstanding op.

Behaviour:
- Reset (async, immediate):
  - busy = 0; FIFO rd/wr pointers = 0; count = 0; err_o = 0;
  - stall_o is then purely combinational from the inputs.
- Issue event:
  - issue = id_valid_i & ~flush_i & ~stall_o & id_long_i.
  - On issue: push id_rd_i into the tag FIFO and increment count. The push happens even if rd = x0 or id_wen_n_i = 1, so completion tracking stays in order.
  - If also ~id_wen_n_i and id_rd_i ≠ 0: set busy[id_rd_i] at the clock edge.
- Completion event:
  - done = lu_done_i & (count ≠ 0).
  - On done: pop the head tag, decrement count, clear busy[head].
  - lu_done_i with count = 0: ignored, and err_o is set (cleared only by reset).
- Simultaneous issue and done:
  - count is unchanged and both pointers advance.
  - If the issued rd equals the popped head, set wins and the bit stays busy.
- Stall (combinational, OR of the terms below):
  - RAW-long: (id_use_rs1_i & busy[rs1] & rs1≠0 & ~(done & head==rs1)). Same term for rs2.
    - A same-cycle completion releases the stall; the WB forwarding path supplies the value.
  - WAW: id_long_i & ~id_wen_n_i & busy[id_rd_i] & id_rd_i≠0 & ~(done & head==id_rd_i).
  - Load-use: ex_load_i & ex_rd_i≠0 & ((id_use_rs1_i & rs1==ex_rd_i) | (id_use_rs2_i & rs2==ex_rd_i)).
  - Structural: id_long_i & (count == DEPTH) & ~done.
  - All terms are gated by id_valid_i & ~flush_i. Flush always wins, and stall_o is 0 during flush.
- Latency: busy/count update on the edge after issue/done. The stall from a new issue is visible to the next ID instruction in the following cycle.
- Pointers wrap modulo DEPTH. full_o = (count == DEPTH).
- x0 is never busy, never causes a stall, and never sets err_o.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5, NUM_REGS = 32;
  - stall cause enum (STALL_NONE, STALL_RAW, STALL_WAW, STALL_LOADUSE, STALL_FULL), exported for debug/perf counters.
- One sub-module: sb_tag_fifo, a DEPTH×5 in-order tag FIFO.
  - Ports: push, pop, head, count, full, empty.
  - Async reset, same as the top block.
- The busy vector and stall logic live in the top module.

Test Plan:
- Reset mid-operation: issue rd=5 long, assert reset_i before completion -> busy_o=0, pending_cnt_o=0, stall_o=0 immediately, with no clock edge needed.
- RAW: issue long rd=7; next cycle ID reads rs1=7 -> stall_o=1 for every cycle until lu_done_i; the cycle lu_done_i pops 7 -> stall_o=0; next edge busy_o[7]=0.
- Load-use: ex_load_i=1, ex_rd_i=3, ID rs2=3 with use_rs2 -> stall_o=1 for one cycle. Same stimulus with ex_rd_i=0, or with id_use_rs2_i=0 -> stall_o=0.
- Full: issue 4 long ops rd=1..4 -> full_o=1, pending_cnt_o=4. 5th long issue -> stall_o=1. Assert lu_done_i in the same cycle -> stall_o=0, issue accepted, count stays 4, busy_o[1]=0.
- Simultaneous same-reg: head=9 completing while a new long op with rd=9 issues -> busy_o[9] remains 1 and count is unchanged.
- Error/flush: lu_done_i with count=0 -> err_o=1 (sticky), count stays 0. flush_i=1 with a hazard present -> stall_o=0 and no FIFO push.
